mrr_loopback_push_ingest: RTL and testbench

Host-side ingest stage that feeds the per-node loopback queue's push port.
- Accepts loopback frames from the host as a 32-bit valid/ready word stream: one chip-ID word, then the message words.
- Assembles each frame and buffers complete frames in a small FIFO.
- Drains the FIFO into the queue through the four-phase push_request/push_ack handshake.
- Decouples host bursts from the queue's multi-cycle push search.

---
 rtl/mrr_loopback_push_ingest_if.sv | 25 ++
 rtl/mrr_loopback_push_ingest.sv | 178 +++++++++++++++++
 tb/tb_mrr_loopback_push_ingest.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mrr_loopback_push_ingest_if.sv
// Host word stream and loopback-queue push handshake bundle.
// The ingest stage uses the slave modport; host and queue models use master.
interface mrr_loopback_push_ingest_if #(
   parameter int CHIP_ID_LEN          = 32,
   parameter int LOOPBACK_MESSAGE_LEN = 64
);
   logic [31:0]                   s_tdata;
   logic                          s_tvalid;
   logic                          s_tlast;
   logic                          s_tready;
   logic [CHIP_ID_LEN-1:0]        push_chip_id;
   logic [LOOPBACK_MESSAGE_LEN-1:0] push_message;
   logic                          push_request;
   logic                          push_ack;

   modport master (
      output s_tdata, s_tvalid, s_tlast, push_ack,
      input  s_tready, push_chip_id, push_message, push_request
   );

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, push_ack,
      output s_tready, push_chip_id, push_message, push_request
   );
endinterface

// File: rtl/mrr_loopback_push_ingest.sv
// Host frame ingest: assembles chip-ID + message frames, buffers them, pushes to loopback queue.
// Optional MRR_LOOPBACK_INGEST_STATS_EN adds saturating accepted/dropped frame counters.
module mrr_loopback_push_ingest #(
   parameter int CHIP_ID_LEN          = 32,
   parameter int LOOPBACK_MESSAGE_LEN = 64,
   parameter int FIFO_DEPTH_LOG2      = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   mrr_loopback_push_ingest_if.slave bus,
   output logic [FIFO_DEPTH_LOG2:0] fifo_level,
   output logic                     drop_pulse
`ifdef MRR_LOOPBACK_INGEST_STATS_EN
   ,
   output logic [15:0]              frames_accepted_count,
   output logic [15:0]              frames_dropped_count
`endif
);
   localparam int MSG_WORDS = LOOPBACK_MESSAGE_LEN / 32;
   localparam int CNT_W     = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
   localparam int STG_W     = (MSG_WORDS > 1) ? LOOPBACK_MESSAGE_LEN - 32 : 32;
   localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
   localparam int ENTRY_W   = CHIP_ID_LEN + LOOPBACK_MESSAGE_LEN;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_WORDS - 1);

   typedef enum logic [1:0] {RX_CHIP, RX_MSG, RX_DISCARD} rx_state_t;
   typedef enum logic [1:0] {PUSH_IDLE, PUSH_REQ, PUSH_RELEASE} push_state_t;

   rx_state_t   rx_state, rx_next;
   push_state_t push_state, push_next;

   logic [CHIP_ID_LEN-1:0]          chip_q;
   logic [STG_W-1:0]                msg_q;
   logic [LOOPBACK_MESSAGE_LEN-1:0] msg_next;
   logic [CNT_W-1:0]                cnt;
   logic [ENTRY_W-1:0]              mem [DEPTH];
   logic [ENTRY_W-1:0]              head;
   logic [FIFO_DEPTH_LOG2:0]        wr_ptr, rd_ptr;
   logic xfer, fifo_wr, take_chip, shift, clear, pop, empty, full;

   if (MSG_WORDS > 1) begin : g_shift
      assign msg_next = {msg_q, bus.s_tdata};
   end else begin : g_single
      assign msg_next = bus.s_tdata;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                  (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
   assign fifo_level = wr_ptr - rd_ptr;
   assign head = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

   // Head is masked while empty so stale entries never reach the queue
   assign bus.push_chip_id = empty ? '0 : head[ENTRY_W-1 -: CHIP_ID_LEN];
   assign bus.push_message = empty ? '0 : head[LOOPBACK_MESSAGE_LEN-1:0];
   assign bus.push_request = (push_state == PUSH_REQ);
   assign bus.s_tready     = (rx_state == RX_DISCARD) | ~full;
   assign xfer             = bus.s_tvalid & bus.s_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= RX_CHIP;
         push_state <= PUSH_IDLE;
      end else begin
         rx_state   <= rx_next;
         push_state <= push_next;
      end
   end

   always_comb begin
      rx_next    = rx_state;
      fifo_wr    = 1'b0;
      drop_pulse = 1'b0;
      take_chip  = 1'b0;
      shift      = 1'b0;
      clear      = 1'b0;
      unique case (rx_state)
         RX_CHIP: begin
            if (xfer) begin
               if (bus.s_tlast) begin
                  drop_pulse = 1'b1;
               end else begin
                  take_chip = 1'b1;
                  rx_next   = RX_MSG;
               end
            end
         end
         RX_MSG: begin
            if (xfer) begin
               shift = 1'b1;
               if (cnt == LAST_CNT) begin
                  if (bus.s_tlast) begin
                     fifo_wr = 1'b1;
                     rx_next = RX_CHIP;
                  end else begin
                     drop_pulse = 1'b1;
                     rx_next    = RX_DISCARD;
                  end
               end else if (bus.s_tlast) begin
                  drop_pulse = 1'b1;
                  clear      = 1'b1;
                  rx_next    = RX_CHIP;
               end
            end
         end
         RX_DISCARD: begin
            if (xfer && bus.s_tlast) rx_next = RX_CHIP;
         end
         default: rx_next = RX_CHIP;
      endcase
   end

   always_comb begin
      push_next = push_state;
      pop       = 1'b0;
      unique case (push_state)
         PUSH_IDLE: begin
            if (!empty && !bus.push_ack) push_next = PUSH_REQ;
         end
         PUSH_REQ: begin
            if (bus.push_ack) begin
               pop       = 1'b1;
               push_next = PUSH_RELEASE;
            end
         end
         PUSH_RELEASE: begin
            if (!bus.push_ack) push_next = PUSH_IDLE;
         end
         default: push_next = PUSH_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chip_q <= '0;
         msg_q  <= '0;
         cnt    <= '0;
      end else if (take_chip) begin
         chip_q <= bus.s_tdata[CHIP_ID_LEN-1:0];
         msg_q  <= '0;
         cnt    <= '0;
      end else if (clear) begin
         msg_q <= '0;
         cnt   <= '0;
      end else if (shift) begin
         msg_q <= msg_next[STG_W-1:0];
         cnt   <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {chip_q, msg_next};
   end

`ifdef MRR_LOOPBACK_INGEST_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frames_accepted_count <= '0;
         frames_dropped_count  <= '0;
      end else begin
         if (fifo_wr && frames_accepted_count != 16'hFFFF)
            frames_accepted_count <= frames_accepted_count + 1'b1;
         if (drop_pulse && frames_dropped_count != 16'hFFFF)
            frames_dropped_count <= frames_dropped_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_mrr_loopback_push_ingest.sv
// Directed and randomized frame ingest checks against a frame-queue model.
// Expected pushes, levels and drops come from the frame rules, not the RTL structure.
module tb_mrr_loopback_push_ingest;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] fifo_level;
   logic       drop_pulse;
`ifdef MRR_LOOPBACK_INGEST_STATS_EN
   logic [15:0] frames_accepted_count;
   logic [15:0] frames_dropped_count;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [95:0] exp_q[$];

   mrr_loopback_push_ingest_if ifc ();

   mrr_loopback_push_ingest dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifc.slave),
      .fifo_level (fifo_level),
      .drop_pulse (drop_pulse)
`ifdef MRR_LOOPBACK_INGEST_STATS_EN
      ,
      .frames_accepted_count (frames_accepted_count),
      .frames_dropped_count  (frames_dropped_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] d, input logic last, input logic exp_drop,
                       input string tag);
      int k;
      k = 0;
      ifc.s_tdata  = d;
      ifc.s_tvalid = 1'b1;
      ifc.s_tlast  = last;
      #1;
      while (!ifc.s_tready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_ready"}, 96'(ifc.s_tready), 96'd1);
      chk({tag, "_drop"}, 96'(drop_pulse), 96'(exp_drop));
      @(posedge clk); #1;
      ifc.s_tvalid = 1'b0;
      ifc.s_tlast  = 1'b0;
   endtask

   task automatic send_good(input logic [31:0] chip, input logic [63:0] msg, input bit enq);
      if (enq) exp_q.push_back({chip, msg});
      xfer(chip, 1'b0, 1'b0, "chip");
      xfer(msg[63:32], 1'b0, 1'b0, "msg_hi");
      xfer(msg[31:0], 1'b1, 1'b0, "msg_lo");
   endtask

   task automatic drain_one(input int hold, input bit chk_lvl);
      int k;
      logic [95:0] e;
      k = 0;
      while (!ifc.push_request && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("req_up", 96'(ifc.push_request), 96'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("head", {ifc.push_chip_id, ifc.push_message}, e);
      ifc.push_ack = 1'b1;
      @(posedge clk); #1;
      chk("req_drop", 96'(ifc.push_request), 96'd0);
      if (chk_lvl) chk("level_pop", 96'(fifo_level), 96'(exp_q.size()));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("req_ack_high", 96'(ifc.push_request), 96'd0);
      end
      ifc.push_ack = 1'b0;
      @(posedge clk); #1;
      chk("req_gap", 96'(ifc.push_request), 96'd0);
   endtask

   initial begin
      logic [31:0] chip;
      logic [63:0] msg;
      int n, kind, k;
      ifc.s_tdata  = '0;
      ifc.s_tvalid = 1'b0;
      ifc.s_tlast  = 1'b0;
      ifc.push_ack = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 96'(ifc.push_request), 96'd0);
      chk("rst_level", 96'(fifo_level), 96'd0);
      chk("rst_drop", 96'(drop_pulse), 96'd0);
      chk("rst_ready", 96'(ifc.s_tready), 96'd1);
      chk("rst_head", {ifc.push_chip_id, ifc.push_message}, 96'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Well-formed frame and the two-cycle request latency
      send_good(32'h5, 64'hDEADBEEF_01234567, 1'b1);
      chk("lat_req_n1", 96'(ifc.push_request), 96'd0);
      chk("lat_level", 96'(fifo_level), 96'd1);
      @(posedge clk); #1;
      chk("lat_req_n2", 96'(ifc.push_request), 96'd1);
      drain_one(0, 1'b1);
      chk("lat_level0", 96'(fifo_level), 96'd0);

      // Five frames against a stalled queue
      for (int i = 0; i < 4; i++)
         send_good(32'h10 + i, {$urandom, $urandom}, 1'b1);
      chk("burst_level4", 96'(fifo_level), 96'd4);
      chip = 32'h14;
      msg  = {$urandom, $urandom};
      exp_q.push_back({chip, msg});
      ifc.s_tdata  = chip;
      ifc.s_tvalid = 1'b1;
      #1;
      chk("burst_stall", 96'(ifc.s_tready), 96'd0);
      fork
         send_good(chip, msg, 1'b0);
         for (int i = 0; i < 5; i++) drain_one(i % 2, 1'b0);
      join
      chk("burst_level0", 96'(fifo_level), 96'd0);

      // Short frame, chip word with tlast, long frame
      xfer(32'h7, 1'b0, 1'b0, "short_chip");
      xfer(32'hAAAA5555, 1'b1, 1'b1, "short_msg");
      chk("short_level", 96'(fifo_level), 96'd0);
      xfer(32'h8, 1'b1, 1'b1, "lone_chip");
      xfer(32'h9, 1'b0, 1'b0, "long_chip");
      xfer(32'h1, 1'b0, 1'b0, "long_w1");
      xfer(32'h2, 1'b0, 1'b1, "long_w2");
      xfer(32'h3, 1'b1, 1'b0, "long_w3");
      @(posedge clk); #1;
      chk("long_level", 96'(fifo_level), 96'd0);
      chk("long_noreq", 96'(ifc.push_request), 96'd0);
      send_good(32'h6, 64'h0123456789ABCDEF, 1'b1);
      drain_one(0, 1'b1);

      // Acknowledge held high after the request falls
      send_good(32'h21, {$urandom, $urandom}, 1'b1);
      send_good(32'h22, {$urandom, $urandom}, 1'b1);
      drain_one(5, 1'b1);
      drain_one(0, 1'b1);

      // Reset mid-handshake, then mid-frame
      send_good(32'h31, {$urandom, $urandom}, 1'b1);
      k = 0;
      while (!ifc.push_request && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("pre_rst_req", 96'(ifc.push_request), 96'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_req", 96'(ifc.push_request), 96'd0);
      chk("arst_level", 96'(fifo_level), 96'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(32'h41, 1'b0, 1'b0, "mid_chip");
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send_good(32'h42, 64'hCAFEF00D_12345678, 1'b1);
      drain_one(1, 1'b1);

      // Randomized mix of good and malformed frames
      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) begin
            kind = $urandom_range(0, 5);
            chip = $urandom;
            if (kind == 0) begin
               xfer(chip, 1'b0, 1'b0, "r_short_chip");
               xfer($urandom, 1'b1, 1'b1, "r_short_msg");
            end else if (kind == 1) begin
               xfer(chip, 1'b0, 1'b0, "r_long_chip");
               xfer($urandom, 1'b0, 1'b0, "r_long_w1");
               xfer($urandom, 1'b0, 1'b1, "r_long_w2");
               for (int x = 0; x < int'($urandom_range(0, 2)); x++)
                  xfer($urandom, 1'b0, 1'b0, "r_long_extra");
               xfer($urandom, 1'b1, 1'b0, "r_long_end");
            end else if (kind == 2) begin
               xfer(chip, 1'b1, 1'b1, "r_lone_chip");
            end else begin
               send_good(chip, {$urandom, $urandom}, 1'b1);
            end
         end
         chk("r_level", 96'(fifo_level), 96'(exp_q.size()));
         while (exp_q.size() > 0) drain_one($urandom_range(0, 3), 1'b1);
      end
      chk("final_level", 96'(fifo_level), 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
